serial_alu_pw: RTL and testbench

Parametrised bit-serial ALU: accepts two WIDTH-bit operands and a 3-bit function code on a valid/ready input port, processes one bit per clock LSB-first, and presents the result on a valid/ready output port with backpressure. It is the next-generation serial datapath unit used where area matters more than throughput. It adds configurable width, subtraction, eight functions, an output handshake and optional status flags.

---
 rtl/serial_alu_pw_if.sv | 25 ++
 rtl/serial_alu_pw.sv | 123 ++++++++++++
 tb/tb_serial_alu_pw.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_pw_if.sv
// rtl/serial_alu_pw_if.sv - operand/result handshake bundle for serial_alu_pw
interface serial_alu_pw_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din_di1;
    logic [WIDTH-1:0] din_di2;
    logic [2:0]       din_fun;
    logic             din_vld;
    logic             din_rdy;
    logic [WIDTH-1:0] dout_dat;
    logic             dout_cout;
    logic             dout_zero;
    logic             dout_vld;
    logic             dout_rdy;

    modport master (
        output din_di1, din_di2, din_fun, din_vld, dout_rdy,
        input  din_rdy, dout_dat, dout_cout, dout_zero, dout_vld
    );

    modport slave (
        input  din_di1, din_di2, din_fun, din_vld, dout_rdy,
        output din_rdy, dout_dat, dout_cout, dout_zero, dout_vld
    );
endinterface

// File: rtl/serial_alu_pw.sv
// rtl/serial_alu_pw.sv - bit-serial LSB-first ALU, eight functions, valid/ready in and out
// Optional macro SERIAL_ALU_PW_FLAGS_EN enables the carry-out and zero flag outputs.
module serial_alu_pw #(
    parameter int WIDTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    serial_alu_pw_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       fun_q, fun_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             arith;
    logic             bx;
    logic             rbit;
`ifdef SERIAL_ALU_PW_FLAGS_EN
    logic             nz_q, nz_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ALU_PW_FLAGS_EN
            nz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
`ifdef SERIAL_ALU_PW_FLAGS_EN
            nz_q    <= nz_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
`ifdef SERIAL_ALU_PW_FLAGS_EN
        nz_d    = nz_q;
`endif
        // Subtraction is A + ~B + 1: invert B per bit, carry seeded with 1 at accept.
        arith = (fun_q[2:1] == 2'b00);
        bx    = (fun_q == 3'd1) ? ~b_q[0] : b_q[0];
        rbit  = 1'b0;
        case (fun_q)
            3'd0, 3'd1: rbit = a_q[0] ^ bx ^ carry_q;
            3'd2:       rbit = a_q[0] & b_q[0];
            3'd3:       rbit = a_q[0] | b_q[0];
            3'd4:       rbit = a_q[0] ^ b_q[0];
            3'd5:       rbit = ~(a_q[0] ^ b_q[0]);
            3'd6:       rbit = ~(a_q[0] | b_q[0]);
            default:    rbit = ~(a_q[0] & b_q[0]);
        endcase

        case (state_q)
            IDLE: begin
                if (bus.din_vld) begin
                    a_d     = bus.din_di1;
                    b_d     = bus.din_di2;
                    fun_d   = bus.din_fun;
                    cnt_d   = CW'(WIDTH - 1);
                    carry_d = (bus.din_fun == 3'd1);
`ifdef SERIAL_ALU_PW_FLAGS_EN
                    nz_d    = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Result bits enter at the top so A holds the full result after WIDTH shifts.
                a_d = {rbit, a_q[WIDTH-1:1]};
                b_d = {1'b0, b_q[WIDTH-1:1]};
                if (arith) begin
                    carry_d = (a_q[0] & bx) | (a_q[0] & carry_q) | (bx & carry_q);
                end
`ifdef SERIAL_ALU_PW_FLAGS_EN
                nz_d = nz_q | rbit;
`endif
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.dout_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.din_rdy  = (state_q == IDLE);
    assign bus.dout_vld = (state_q == DONE);
    assign bus.dout_dat = a_q;
`ifdef SERIAL_ALU_PW_FLAGS_EN
    assign bus.dout_cout = carry_q;
    assign bus.dout_zero = (state_q == DONE) & ~nz_q;
`else
    assign bus.dout_cout = 1'b0;
    assign bus.dout_zero = 1'b0;
`endif
endmodule

// File: tb/tb_serial_alu_pw.sv
// tb/tb_serial_alu_pw.sv - self-checking bench for serial_alu_pw (WIDTH 8 and 16 instances)
module tb_serial_alu_pw;
`ifdef SERIAL_ALU_PW_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    serial_alu_pw_if #(.WIDTH(8))  bus8();
    serial_alu_pw_if #(.WIDTH(16)) bus16();

    serial_alu_pw #(.WIDTH(8))  u8  (.clock(clock), .reset(reset), .bus(bus8));
    serial_alu_pw #(.WIDTH(16)) u16 (.clock(clock), .reset(reset), .bus(bus16));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result: {dat[7:0], cout, zero}
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        c = 1'b0;
        case (f)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: r = ~(a | b);
            default: r = ~(a & b);
        endcase
        return {r, c & FL, (r == 8'h00) & FL};
    endfunction

    logic       m_pending = 1'b0;
    int         m_cnt = 0;
    logic [9:0] m_exp = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_pending <= 1'b0;
        end else if (!m_pending) begin
            if (bus8.din_vld) begin
                m_pending <= 1'b1;
                m_cnt     <= 0;
                m_exp     <= model8(bus8.din_di1, bus8.din_di2, bus8.din_fun);
            end
        end else if (m_cnt < 8) begin
            m_cnt <= m_cnt + 1;
        end else if (bus8.dout_rdy) begin
            m_pending <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("din_rdy", 64'(bus8.din_rdy), 64'(!m_pending));
            check("dout_vld", 64'(bus8.dout_vld), 64'(m_pending && m_cnt == 8));
            if (m_pending && m_cnt == 8) begin
                check("dout_dat", 64'(bus8.dout_dat), 64'(m_exp[9:2]));
                check("dout_cout", 64'(bus8.dout_cout), 64'(m_exp[1]));
                check("dout_zero", 64'(bus8.dout_zero), 64'(m_exp[0]));
            end
        end
    end

    // Entered and left at posedge+1 with the 8-bit unit idle; dout_rdy is assumed high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                          input logic [7:0] ed, input logic ec, input logic ez, input string nm);
        int edges;
        bus8.din_di1 = a;
        bus8.din_di2 = b;
        bus8.din_fun = f;
        bus8.din_vld = 1'b1;
        @(posedge clock);
        edges = 1;
        #1;
        bus8.din_vld = 1'b0;
        bus8.din_di1 = ~a;
        bus8.din_di2 = ~b;
        while (!bus8.dout_vld && edges < 40) begin
            @(posedge clock);
            edges++;
            #1;
        end
        check({nm, "_latency"}, 64'(edges), 64'd9);
        check({nm, "_dat"}, 64'(bus8.dout_dat), 64'(ed));
        check({nm, "_cout"}, 64'(bus8.dout_cout), 64'(ec & FL));
        check({nm, "_zero"}, 64'(bus8.dout_zero), 64'(ez & FL));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] la [6];
        logic [7:0] lb [6];
        logic [2:0] lf [6];
        logic [7:0] sweep [6];
        int edges;
        logic [7:0] held;

        bus8.din_di1 = '0; bus8.din_di2 = '0; bus8.din_fun = '0;
        bus8.din_vld = 1'b0; bus8.dout_rdy = 1'b1;
        bus16.din_di1 = '0; bus16.din_di2 = '0; bus16.din_fun = '0;
        bus16.din_vld = 1'b0; bus16.dout_rdy = 1'b1;
        bus8.din_vld = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        bus8.din_vld = 1'b0;
        reset = 1'b0;
        check("rst_rdy", 64'(bus8.din_rdy), 64'd1);
        check("rst_vld", 64'(bus8.dout_vld), 64'd0);
        check("rst_dat", 64'(bus8.dout_dat), 64'd0);
        check("rst_cout", 64'(bus8.dout_cout), 64'd0);
        check("rst_zero", 64'(bus8.dout_zero), 64'd0);

        run_op(8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, "add7f");
        run_op(8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, "addff");
        run_op(8'h05, 8'h07, 3'd1, 8'hFE, 1'b0, 1'b0, "sub57");
        run_op(8'h07, 8'h05, 3'd1, 8'h02, 1'b1, 1'b0, "sub75");
        run_op(8'h33, 8'h33, 3'd1, 8'h00, 1'b1, 1'b1, "subeq");

        sweep = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'h50, 8'hFA};
        for (int i = 0; i < 6; i++) begin
            run_op(8'hA5, 8'h0F, 3'(i + 2), sweep[i], 1'b0, 1'b0, $sformatf("logic%0d", i + 2));
        end

        // Backpressure, with a competing request offered while the result waits.
        bus8.dout_rdy = 1'b0;
        bus8.din_di1 = 8'h12; bus8.din_di2 = 8'h34; bus8.din_fun = 3'd0; bus8.din_vld = 1'b1;
        @(posedge clock);
        #1;
        bus8.din_di1 = 8'hEE; bus8.din_di2 = 8'hEE; bus8.din_fun = 3'd4;
        edges = 1;
        while (!bus8.dout_vld && edges < 40) begin
            @(posedge clock);
            edges++;
            #1;
        end
        check("bp_dat", 64'(bus8.dout_dat), 64'h46);
        held = bus8.dout_dat;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("bp_hold_vld", 64'(bus8.dout_vld), 64'd1);
            check("bp_hold_dat", 64'(bus8.dout_dat), 64'(held));
            check("bp_hold_rdy", 64'(bus8.din_rdy), 64'd0);
        end
        bus8.dout_rdy = 1'b1;
        bus8.din_vld = 1'b0;
        @(posedge clock);
        #1;
        check("bp_release_vld", 64'(bus8.dout_vld), 64'd0);
        check("bp_release_rdy", 64'(bus8.din_rdy), 64'd1);

        // Reset in the middle of a shift sequence.
        bus8.din_di1 = 8'h55; bus8.din_di2 = 8'h66; bus8.din_fun = 3'd1; bus8.din_vld = 1'b1;
        @(posedge clock);
        #1;
        bus8.din_vld = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_rdy", 64'(bus8.din_rdy), 64'd1);
        check("mid_rst_vld", 64'(bus8.dout_vld), 64'd0);
        check("mid_rst_dat", 64'(bus8.dout_dat), 64'd0);
        check("mid_rst_cout", 64'(bus8.dout_cout), 64'd0);
        check("mid_rst_zero", 64'(bus8.dout_zero), 64'd0);
        run_op(8'h10, 8'h20, 3'd0, 8'h30, 1'b0, 1'b0, "post_rst_add");

        // Back-to-back requests with din_vld held high; the model checks every cycle.
        la = '{8'hC8, 8'h01, 8'h80, 8'h3C, 8'h00, 8'hF0};
        lb = '{8'h64, 8'h02, 8'h80, 8'hC3, 8'h00, 8'h0F};
        lf = '{3'd0, 3'd1, 3'd0, 3'd7, 3'd5, 3'd6};
        for (int i = 0; i < 6; i++) begin
            bus8.din_di1 = la[i]; bus8.din_di2 = lb[i]; bus8.din_fun = lf[i]; bus8.din_vld = 1'b1;
            edges = 0;
            while (!bus8.din_rdy && edges < 40) begin
                @(posedge clock);
                edges++;
                #1;
            end
            if (i > 0) check("b2b_interval", 64'(edges), 64'd9);
            @(posedge clock);
            #1;
        end
        bus8.din_vld = 1'b0;
        repeat (12) @(posedge clock);
        #1;

        // 16-bit instance: wraparound add.
        bus16.din_di1 = 16'hFFFF; bus16.din_di2 = 16'h0001; bus16.din_fun = 3'd0; bus16.din_vld = 1'b1;
        @(posedge clock);
        #1;
        bus16.din_vld = 1'b0;
        edges = 1;
        while (!bus16.dout_vld && edges < 60) begin
            @(posedge clock);
            edges++;
            #1;
        end
        check("w16_latency", 64'(edges), 64'd17);
        check("w16_dat", 64'(bus16.dout_dat), 64'h0000);
        check("w16_cout", 64'(bus16.dout_cout), 64'(FL));
        check("w16_zero", 64'(bus16.dout_zero), 64'(FL));
        @(posedge clock);
        #1;
        check("w16_release", 64'(bus16.dout_vld), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
